// File: rtl/bit_order_deser_pkg.sv
// Shared definitions for the bit-reordering datapath (deserializer and serializer).
package bit_order_deser_pkg;

  typedef enum logic {
    ORDER_MSB_FIRST = 1'b0,
    ORDER_LSB_FIRST = 1'b1
  } bit_order_e;

  // Bit-counter width for a given word width; never below one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_order_out_stage.sv
// Single-entry valid/ready holding register: load, drain, hold, same-edge replace.
module bit_order_out_stage
  import bit_order_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state: a load wins over a drain so replace-on-drain keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bit_order_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a 1-bit valid/ready stream.
module bit_order_deser
  import bit_order_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_bit,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             err_sof
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam bit_order_e       ORDER    = (LSB_FIRST != 0) ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             err_q;
  logic             err_d;

  logic             accept_s;
  logic             restart_s;
  logic             complete_s;
  logic [CNT_W-1:0] k_s;
  logic [CNT_W-1:0] pos_s;
  logic [WIDTH-1:0] word_s;

  // Only the completing bit stalls, and only while the previous word is still held.
  assign s_ready = !((cnt_q == LAST_IDX) && m_valid && !m_ready);

  // Bit placement, s_sof restart and word completion.
  always_comb begin
    accept_s   = s_valid && s_ready;
    restart_s  = accept_s && s_sof && (cnt_q != '0);
    k_s        = restart_s ? '0 : cnt_q;
    pos_s      = (ORDER == ORDER_LSB_FIRST) ? k_s : (LAST_IDX - k_s);
    word_s     = restart_s ? '0 : shreg_q;
    word_s[pos_s] = s_bit;
    complete_s = accept_s && !restart_s && (cnt_q == LAST_IDX);
    err_d      = restart_s;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    if (complete_s) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (accept_s) begin
      cnt_d   = k_s + CNT_W'(1);
      shreg_d = word_s;
    end else begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
    end
  end

  // Word-assembly state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
    end
  end

  assign err_sof = err_q;

  bit_order_out_stage #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load_i (complete_s),
    .data_i (word_s),
    .ready_i(m_ready),
    .valid_o(m_valid),
    .data_o (m_data)
  );

endmodule

// File: tb/tb_bit_order_deser.sv
// Directed bench for bit_order_deser: LSB-first instance plus an MSB-first twin on the same stream.
module tb_bit_order_deser;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_bit;
  logic       s_sof;
  logic       m_ready;
  logic       s_ready_l, m_valid_l, err_l;
  logic [7:0] m_data_l;
  logic       s_ready_m, m_valid_m, err_m;
  logic [7:0] m_data_m;

  int n_checks = 0;
  int n_fail   = 0;

  bit_order_deser #(.WIDTH(8), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_l), .s_bit(s_bit),
    .s_sof(s_sof), .m_valid(m_valid_l), .m_ready(m_ready), .m_data(m_data_l),
    .err_sof(err_l)
  );

  bit_order_deser #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_m), .s_bit(s_bit),
    .s_sof(s_sof), .m_valid(m_valid_m), .m_ready(m_ready), .m_data(m_data_m),
    .err_sof(err_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs set at a falling edge, consumed at the rising edge, back at the next falling edge.
  task automatic drive(input logic v, input logic b, input logic sof);
    s_valid = v;
    s_bit   = b;
    s_sof   = sof;
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive(1'b1, w[i], 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (s_ready_l !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready got=%b exp=1", s_ready_l); end
    n_checks++; if (m_valid_l !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got=%b exp=0", m_valid_l); end
    n_checks++; if (m_data_l !== 8'h00) begin n_fail++; $display("FAIL rst_m_data got=%h exp=00", m_data_l); end
    n_checks++; if (err_l !== 1'b0) begin n_fail++; $display("FAIL rst_err_sof got=%b exp=0", err_l); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    bits = 8'b0100_1101;  // stream order 1,0,1,1,0,0,1,0 from bit 0 upward
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive(1'b1, bits[i], 1'b0);
    n_checks++; if (m_valid_l !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", m_valid_l); end
    drive(1'b1, bits[7], 1'b0);
    n_checks++; if (m_valid_l !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", m_valid_l); end
    n_checks++; if (m_data_l !== 8'h4D) begin n_fail++; $display("FAIL basic_lsb_data got=%h exp=4d", m_data_l); end
    n_checks++; if (m_data_m !== 8'hB2) begin n_fail++; $display("FAIL basic_msb_data got=%h exp=b2", m_data_m); end
    n_checks++; if (m_valid_m !== 1'b1) begin n_fail++; $display("FAIL basic_msb_valid got=%b exp=1", m_valid_m); end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (m_valid_l !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", m_valid_l); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    w = 8'h3C;
    m_ready = 1'b0;
    send_word(8'hA5);
    n_checks++; if (m_data_l !== 8'hA5) begin n_fail++; $display("FAIL bp_first got=%h exp=a5", m_data_l); end
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_bit = w[i]; #1;
      n_checks++; if (s_ready_l !== 1'b1) begin n_fail++; $display("FAIL bp_early_ready bit=%0d got=%b exp=1", i, s_ready_l); end
      @(negedge clk);
    end
    s_valid = 1'b1; s_bit = w[7]; #1;
    n_checks++; if (s_ready_l !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got=%b exp=0", s_ready_l); end
    @(negedge clk);
    n_checks++; if (m_data_l !== 8'hA5 || m_valid_l !== 1'b1) begin n_fail++; $display("FAIL bp_hold got=%h/%b exp=a5/1", m_data_l, m_valid_l); end
    m_ready = 1'b1; #1;
    n_checks++; if (s_ready_l !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", s_ready_l); end
    @(negedge clk);
    m_ready = 1'b0; s_valid = 1'b0; #1;
    n_checks++; if (m_valid_l !== 1'b1 || m_data_l !== 8'h3C) begin n_fail++; $display("FAIL bp_replace got=%h/%b exp=3c/1", m_data_l, m_valid_l); end
    m_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_valid_l !== 1'b0) begin n_fail++; $display("FAIL bp_final_drain got=%b exp=0", m_valid_l); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    words = '{8'h01, 8'h80, 8'hFF, 8'h00};
    m_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_valid = 1'b1; s_bit = words[i / 8][i % 8]; #1;
      n_checks++; if (s_ready_l !== 1'b1) begin n_fail++; $display("FAIL b2b_ready bit=%0d got=%b exp=1", i, s_ready_l); end
      @(negedge clk);
      n_checks++; if (m_valid_l !== ((i % 8) == 7)) begin n_fail++; $display("FAIL b2b_valid bit=%0d got=%b exp=%b", i, m_valid_l, ((i % 8) == 7)); end
      if ((i % 8) == 7) begin
        n_checks++; if (m_data_l !== words[i / 8]) begin n_fail++; $display("FAIL b2b_data word=%0d got=%h exp=%h", i / 8, m_data_l, words[i / 8]); end
      end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sof();
    logic [7:0] tail;
    tail = 8'b1000_0000;  // tail bits 0,0,0,0,0,0,1 in tail[1..7]
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    n_checks++; if (err_l !== 1'b0) begin n_fail++; $display("FAIL sof_early_err got=%b exp=0", err_l); end
    drive(1'b1, 1'b1, 1'b1);
    n_checks++; if (err_l !== 1'b1) begin n_fail++; $display("FAIL sof_err_pulse got=%b exp=1", err_l); end
    n_checks++; if (m_valid_l !== 1'b0) begin n_fail++; $display("FAIL sof_no_output got=%b exp=0", m_valid_l); end
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, tail[i], 1'b0);
      if (i == 1) begin
        n_checks++; if (err_l !== 1'b0) begin n_fail++; $display("FAIL sof_err_width got=%b exp=0", err_l); end
      end
    end
    n_checks++; if (m_valid_l !== 1'b1 || m_data_l !== 8'h81) begin n_fail++; $display("FAIL sof_word got=%h/%b exp=81/1", m_data_l, m_valid_l); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    send_word(8'h99);
    n_checks++; if (m_valid_l !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got=%b exp=1", m_valid_l); end
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (m_valid_l !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", m_valid_l); end
    n_checks++; if (m_data_l !== 8'h00) begin n_fail++; $display("FAIL ar_data got=%h exp=00", m_data_l); end
    n_checks++; if (s_ready_l !== 1'b1) begin n_fail++; $display("FAIL ar_ready got=%b exp=1", s_ready_l); end
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    send_word(8'h5A);
    n_checks++; if (m_valid_l !== 1'b1 || m_data_l !== 8'h5A) begin n_fail++; $display("FAIL ar_next_word got=%h/%b exp=5a/1", m_data_l, m_valid_l); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    logic [7:0] exp_w [2];
    int         seen;
    exp_w = '{8'hC3, 8'h7E};
    seen  = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int g = $urandom_range(1, 0); g > 0; g--) begin
        drive(1'b0, 1'b1, 1'b0);
        if (m_valid_l === 1'b1) begin
          n_checks++; if (seen >= 2 || m_data_l !== exp_w[seen % 2]) begin n_fail++; $display("FAIL gap_data idx=%0d got=%h", seen, m_data_l); end
          seen++;
        end
      end
      drive(1'b1, exp_w[i / 8][i % 8], 1'b0);
      if (m_valid_l === 1'b1) begin
        n_checks++; if (seen >= 2 || m_data_l !== exp_w[seen % 2]) begin n_fail++; $display("FAIL gap_data idx=%0d got=%h", seen, m_data_l); end
        seen++;
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (seen != 2) begin n_fail++; $display("FAIL gap_count got=%0d exp=2", seen); end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_sof();
    test_async_reset();
    test_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_order_deser.md
Name: bit_order_deser

Overview:
- Serial-to-parallel receiver for the bit-reordering datapath. Accepts one bit per cycle over a valid/ready stream and assembles WIDTH-bit words.
- Words are restored in natural order whether the far end sent LSB-first or MSB-first.
- Sits after serial transport links, feeding parallel consumers through a single-entry output register with valid/ready handshake.

Parameters:
- WIDTH, 8, word width in bits; legal values 2..64.
- LSB_FIRST, 1, 1: the first accepted bit lands at m_data[0]. 0: the first accepted bit lands at m_data[WIDTH-1].

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  serial bit valid.
- s_ready  output  1  block can accept s_bit this cycle.
- s_bit  input  1  serial data bit.
- s_sof  input  1  qualifies s_bit as bit 0 of a new word (optional marker).
- m_valid  output  1  m_data holds a complete word.
- m_ready  input  1  consumer accepts m_data.
- m_data  output  WIDTH  assembled word.
- err_sof  output  1  one-cycle pulse: partial word discarded by s_sof.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: s_ready=1, m_valid=0, m_data=0, err_sof=0, bit counter=0, shift register=0.
- Reset mid-word or with m_valid=1 discards all held data, with no output.
- Accept condition: s_valid && s_ready. A bit presented with s_valid=0 is ignored; gaps are allowed anywhere.
- Counter cnt, width $clog2(WIDTH), holds bits already accepted for the current word.
- Bit placement: the k-th accepted bit (k=cnt) goes to position k if LSB_FIRST=1, else position WIDTH-1-k.
- Word completion occurs when a bit is accepted with cnt==WIDTH-1:
  - The full word, including the current bit, loads into the output register on that edge.
  - m_valid=1 from the next cycle; latency is 1 cycle from the last-bit handshake.
  - cnt wraps to 0.
- Output register:
  - m_data and m_valid are held stable while m_valid && !m_ready.
  - m_valid clears on m_valid && m_ready unless a new word loads on the same edge.
- Backpressure: s_ready = !(cnt==WIDTH-1 && m_valid && !m_ready).
  - Bits 0..WIDTH-2 of the next word are always accepted while the previous word waits.
  - Only the completing bit stalls.
- Simultaneous drain and complete: when m_valid && m_ready in the same cycle as the completing bit, the new word replaces the old one. m_valid stays 1 with no bubble. Sustained throughput is one word per WIDTH cycles.
- s_sof handling:
  - Accepted with cnt==0: normal first bit.
  - Accepted with cnt!=0: the partial word is discarded, err_sof=1 the next cycle for exactly 1 cycle, the bit is stored as bit 0, and cnt=1.
  - s_sof never affects the output register.
- Bits accepted with cnt==0 and s_sof=0 start a word normally; s_sof is not required.
- No combinational path from s_* to m_*. s_ready depends only on registered state and m_ready.

Decomposition:
- Shared package:
  - the CNT_W function/localparam ($clog2(WIDTH));
  - the bit-order enum constants (ORDER_LSB_FIRST=1, ORDER_MSB_FIRST=0), shared with the matching serializer.
- One sub-module: bit_order_out_stage, the single-entry valid/ready holding register (load, drain, hold, same-edge replace). It is reused by the serializer's input side.
- The counter, placement and s_sof logic stay in the top module.

Test Plan:
- LSB_FIRST=1, m_ready=1, bits 1,0,1,1,0,0,1,0 back-to-back -> m_data=8'h4D with m_valid high for 1 cycle, one cycle after the 8th bit. The same stream with LSB_FIRST=0 -> 8'hB2.
- m_ready=0, stream 0xA5 then 0x3C, LSB-first -> m_data=0xA5 held; s_ready drops when the 8th bit of 0x3C is presented. Raising m_ready for 1 cycle -> 0x3C is accepted on the next edge and appears next cycle.
- Continuous stream of 4 words (0x01,0x80,0xFF,0x00) with m_ready=1 -> m_valid every 8th cycle, s_ready never low, no bubble at the drain/complete overlap.
- 3 bits, then s_sof with bit 1, then 7 more bits 0,0,0,0,0,0,1 (LSB-first) -> err_sof pulses once; next word m_data=8'h81.
- Assert rst asynchronously after 5 bits and mid-clock -> outputs return to reset values immediately; the next 8 bits (0x5A) produce m_data=8'h5A with no residue.
- Random s_valid gaps (≈50% duty) with words 0xC3, 0x7E -> identical m_data sequence to the gap-free run.
